// File: rtl/st_ir_stage_decode_if.sv
// Instruction-register stage bus: capture controls and instruction in,
// register indices and hazard Tuse/Tnew codes out.
`timescale 1ns/1ps

interface st_ir_stage_decode_if;
   logic        en;
   logic        flush;
   logic [31:0] instr;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  GRFaddr;
   logic [2:0]  Drs_use;
   logic [2:0]  Drt_use;
   logic [2:0]  Euse;
   logic [2:0]  Muse;

   modport master (
      output en, flush, instr,
      input  rs, rt, GRFaddr, Drs_use, Drt_use, Euse, Muse
   );

   modport slave (
      input  en, flush, instr,
      output rs, rt, GRFaddr, Drs_use, Drt_use, Euse, Muse
   );
endinterface

// File: rtl/st_ir_stage_decode.sv
// D-stage instruction register with hazard-control decode (dest reg, Tuse, Tnew).
// Optional macro ST_IR_EXT_INSTR_EN widens the decoded instruction set.
`timescale 1ns/1ps

module st_ir_stage_decode (
   input logic                 clk,
   input logic                 reset,
   st_ir_stage_decode_if.slave bus
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_JAL   = 6'h03,
      OP_BEQ   = 6'h04,
      OP_BNE   = 6'h05,
      OP_ADDI  = 6'h08,
      OP_ANDI  = 6'h0c,
      OP_ORI   = 6'h0d,
      OP_LUI   = 6'h0f,
      OP_LB    = 6'h20,
      OP_LH    = 6'h21,
      OP_LW    = 6'h23,
      OP_SB    = 6'h28,
      OP_SH    = 6'h29,
      OP_SW    = 6'h2b
   } opcode_e;

   typedef enum logic [5:0] {
      FN_JR   = 6'h08,
      FN_JALR = 6'h09,
      FN_ADD  = 6'h20,
      FN_SUB  = 6'h22,
      FN_AND  = 6'h24,
      FN_OR   = 6'h25,
      FN_SLT  = 6'h2a
   } funct_e;

   // Only the fields that affect outputs are held; shamt/imm bits never reach the decode.
   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [5:0] fn;
   } ir_t;

   ir_t ir_d, ir_q;

   logic [4:0] grf_addr;
   logic [2:0] drs_use;
   logic [2:0] drt_use;
   logic [2:0] e_use;
   logic [2:0] m_use;

   always_comb begin
      ir_d = ir_q;
      if (bus.flush) begin
         ir_d = '0;
      end else if (bus.en) begin
         ir_d = '{op: bus.instr[31:26], rs: bus.instr[25:21], rt: bus.instr[20:16],
                  rd: bus.instr[15:11], fn: bus.instr[5:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ir_q <= '0;
      else       ir_q <= ir_d;
   end

   // X/Z opcode or funct bits match no item and fall through to the nop default.
   always_comb begin
      grf_addr = '0;
      drs_use  = 3'd7;
      drt_use  = 3'd7;
      e_use    = 3'd0;
      m_use    = 3'd0;
      case (ir_q.op)
         OP_RTYPE: begin
            case (ir_q.fn)
               FN_ADD, FN_SUB: begin
                  grf_addr = ir_q.rd;
                  drs_use  = 3'd1;
                  drt_use  = 3'd1;
                  e_use    = 3'd1;
               end
`ifdef ST_IR_EXT_INSTR_EN
               FN_AND, FN_OR, FN_SLT: begin
                  grf_addr = ir_q.rd;
                  drs_use  = 3'd1;
                  drt_use  = 3'd1;
                  e_use    = 3'd1;
               end
               FN_JALR: begin
                  grf_addr = ir_q.rd;
                  drs_use  = 3'd0;
               end
`endif
               FN_JR: begin
                  drs_use = 3'd0;
               end
               default: ;
            endcase
         end
`ifdef ST_IR_EXT_INSTR_EN
         OP_ADDI, OP_ANDI,
`endif
         OP_ORI: begin
            grf_addr = ir_q.rt;
            drs_use  = 3'd1;
            e_use    = 3'd1;
         end
         OP_LUI: begin
            grf_addr = ir_q.rt;
            e_use    = 3'd1;
         end
`ifdef ST_IR_EXT_INSTR_EN
         OP_LB, OP_LH,
`endif
         OP_LW: begin
            grf_addr = ir_q.rt;
            drs_use  = 3'd1;
            e_use    = 3'd2;
            m_use    = 3'd1;
         end
`ifdef ST_IR_EXT_INSTR_EN
         OP_SB, OP_SH,
`endif
         OP_SW: begin
            drs_use = 3'd1;
            drt_use = 3'd2;
         end
`ifdef ST_IR_EXT_INSTR_EN
         OP_BNE,
`endif
         OP_BEQ: begin
            drs_use = 3'd0;
            drt_use = 3'd0;
         end
         OP_JAL: begin
            grf_addr = 5'd31;
         end
`ifdef ST_IR_EXT_INSTR_EN
         OP_J: ;
`endif
         default: ;
      endcase
   end

   assign bus.rs      = ir_q.rs;
   assign bus.rt      = ir_q.rt;
   assign bus.GRFaddr = grf_addr;
   assign bus.Drs_use = drs_use;
   assign bus.Drt_use = drt_use;
   assign bus.Euse    = e_use;
   assign bus.Muse    = m_use;

endmodule

// File: tb/tb_st_ir_stage_decode.sv
// Scoreboard bench for st_ir_stage_decode: a reference model of the IR predicts
// every cycle's outputs, plus directed spot checks per scenario.
`timescale 1ns/1ps

module tb_st_ir_stage_decode;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] grf;
      logic [2:0] drs;
      logic [2:0] drt;
      logic [2:0] eu;
      logic [2:0] mu;
   } outs_t;

`ifdef ST_IR_EXT_INSTR_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] ir_model = '0;
   outs_t sb_q[$];

   st_ir_stage_decode_if bus ();

   st_ir_stage_decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic outs_t exp_of(input logic [31:0] ir);
      outs_t o;
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      o = '{rs: ir[25:21], rt: ir[20:16], grf: 5'd0, drs: 3'd7, drt: 3'd7, eu: 3'd0, mu: 3'd0};
      if (op === 6'h00 && (fn === 6'h20 || fn === 6'h22 ||
          (EXT && (fn === 6'h24 || fn === 6'h25 || fn === 6'h2a)))) begin
         o.grf = ir[15:11]; o.drs = 3'd1; o.drt = 3'd1; o.eu = 3'd1;
      end else if (op === 6'h00 && fn === 6'h08) begin
         o.drs = 3'd0;
      end else if (EXT && op === 6'h00 && fn === 6'h09) begin
         o.grf = ir[15:11]; o.drs = 3'd0;
      end else if (op === 6'h0d || (EXT && (op === 6'h08 || op === 6'h0c))) begin
         o.grf = ir[20:16]; o.drs = 3'd1; o.eu = 3'd1;
      end else if (op === 6'h0f) begin
         o.grf = ir[20:16]; o.eu = 3'd1;
      end else if (op === 6'h23 || (EXT && (op === 6'h20 || op === 6'h21))) begin
         o.grf = ir[20:16]; o.drs = 3'd1; o.eu = 3'd2; o.mu = 3'd1;
      end else if (op === 6'h2b || (EXT && (op === 6'h28 || op === 6'h29))) begin
         o.drs = 3'd1; o.drt = 3'd2;
      end else if (op === 6'h04 || (EXT && op === 6'h05)) begin
         o.drs = 3'd0; o.drt = 3'd0;
      end else if (op === 6'h03) begin
         o.grf = 5'd31;
      end
      return o;
   endfunction

   function automatic outs_t observe();
      return '{rs: bus.rs, rt: bus.rt, grf: bus.GRFaddr, drs: bus.Drs_use,
               drt: bus.Drt_use, eu: bus.Euse, mu: bus.Muse};
   endfunction

   // Drives one edge's inputs and queues the model's prediction for that edge.
   task automatic drive(input logic r, input logic e, input logic f, input logic [31:0] i);
      @(negedge clk);
      reset     = r;
      bus.en    = e;
      bus.flush = f;
      bus.instr = i;
      if (r || f)  ir_model = '0;
      else if (e)  ir_model = i;
      sb_q.push_back(exp_of(ir_model));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic monitor_loop();
      outs_t e;
      outs_t a;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL scoreboard t=%0t act=%h exp=%h", $time, a, e);
            end
         end
      end
   endtask

   task automatic test_reset();
      outs_t a;
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset act=%h exp=%h", a, outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0});
      end
   endtask

   task automatic test_lw();
      outs_t a;
      drive(1'b0, 1'b1, 1'b0, 32'h8D09_0004);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd8, 5'd9, 5'd9, 3'd1, 3'd7, 3'd2, 3'd1}) begin
         errors++;
         $display("FAIL lw act=%h exp=%h", a, outs_t'{5'd8, 5'd9, 5'd9, 3'd1, 3'd7, 3'd2, 3'd1});
      end
   endtask

   task automatic test_add_stall_beq();
      outs_t a;
      drive(1'b0, 1'b1, 1'b0, 32'h0109_5020);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd8, 5'd9, 5'd10, 3'd1, 3'd1, 3'd1, 3'd0}) begin
         errors++;
         $display("FAIL add act=%h exp=%h", a, outs_t'{5'd8, 5'd9, 5'd10, 3'd1, 3'd1, 3'd1, 3'd0});
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h1109_0003);
         settle();
         a = observe();
         checks++;
         if (a !== outs_t'{5'd8, 5'd9, 5'd10, 3'd1, 3'd1, 3'd1, 3'd0}) begin
            errors++;
            $display("FAIL stall_hold act=%h exp=%h", a, outs_t'{5'd8, 5'd9, 5'd10, 3'd1, 3'd1, 3'd1, 3'd0});
         end
      end
      drive(1'b0, 1'b1, 1'b0, 32'h1109_0003);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd8, 5'd9, 5'd0, 3'd0, 3'd0, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL beq act=%h exp=%h", a, outs_t'{5'd8, 5'd9, 5'd0, 3'd0, 3'd0, 3'd0, 3'd0});
      end
   endtask

   task automatic test_jal_flush();
      outs_t a;
      drive(1'b0, 1'b1, 1'b0, 32'h0C00_0010);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd0, 5'd0, 5'd31, 3'd7, 3'd7, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL jal act=%h exp=%h", a, outs_t'{5'd0, 5'd0, 5'd31, 3'd7, 3'd7, 3'd0, 3'd0});
      end
      // flush wins over a simultaneous enable with a real instruction
      drive(1'b0, 1'b1, 1'b1, 32'h8D09_0004);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL flush act=%h exp=%h", a, outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0});
      end
   endtask

   task automatic test_reset_override();
      outs_t a;
      drive(1'b0, 1'b1, 1'b0, 32'h3509_00FF);
      drive(1'b1, 1'b1, 1'b0, 32'h8D09_0004);
      settle();
      a = observe();
      checks++;
      if (a !== outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset_override act=%h exp=%h", a, outs_t'{5'd0, 5'd0, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0});
      end
   endtask

   task automatic test_x();
      outs_t a;
      outs_t e;
      logic [31:0] xi;
      for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 1'b0, 32'h0);
      xi = 32'bx;
      drive(1'b0, 1'b1, 1'b0, xi);
      settle();
      a = observe();
      e = exp_of(xi);
      checks++;
      if (a.rs !== xi[25:21] || a.rt !== xi[20:16] || a.grf !== e.grf ||
          a.drs !== e.drs || a.drt !== e.drt || a.eu !== e.eu || a.mu !== e.mu) begin
         errors++;
         $display("FAIL x_instr act=%h exp=%h", a, e);
      end
   endtask

   task automatic test_ext_addi();
      outs_t a;
      outs_t e;
      drive(1'b0, 1'b1, 1'b0, 32'h2109_0001);
      settle();
      a = observe();
      e = EXT ? outs_t'{5'd8, 5'd9, 5'd9, 3'd1, 3'd7, 3'd1, 3'd0}
              : outs_t'{5'd8, 5'd9, 5'd0, 3'd7, 3'd7, 3'd0, 3'd0};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL addi act=%h exp=%h", a, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tbl [20];
      tbl = '{32'h0109_5020, 32'h0109_5022, 32'h3509_00FF, 32'h3C09_1234, 32'hAD09_0008,
              32'h01E0_0008, 32'h0109_5024, 32'h0109_5025, 32'h0109_502A, 32'h3109_000F,
              32'h8109_0000, 32'h8509_0000, 32'hA109_0000, 32'hA509_0000, 32'h1509_0003,
              32'h0800_0010, 32'h0100_F809, 32'h0009_4080, 32'hFC00_0000, 32'h8FBF_0010};
      for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 1'b0, tbl[k]);
      for (int k = 0; k < 60; k++) begin
         drive(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               tbl[$urandom_range(0, 19)]);
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.en    = 1'b0;
      bus.flush = 1'b0;
      bus.instr = '0;
      fork
         monitor_loop();
         begin
            #200000;
            $display("FAIL watchdog expired at t=%0t", $time);
            $fatal(1);
         end
      join_none
      test_reset();
      test_lw();
      test_add_stall_beq();
      test_jal_flush();
      test_reset_override();
      test_x();
      test_ext_addi();
      test_back_to_back();
      settle();
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
